// File: rtl/seg7_serial_drv_if.sv
// Bundle of display data, frame control and serial-chain outputs for seg7_serial_drv.
// master drives display data and update; slave is the driver producing the chain signals.
interface seg7_serial_drv_if;
   logic [31:0] Disp_num;
   logic [7:0]  point_in;
   logic [7:0]  LE_in;
   logic        blink;
   logic        update;
   logic        seg_clk;
   logic        seg_sout;
   logic        seg_pen;
   logic        seg_clrn;
   logic        busy;

   modport master (
      output Disp_num, point_in, LE_in, blink, update,
      input  seg_clk, seg_sout, seg_pen, seg_clrn, busy
   );

   modport slave (
      input  Disp_num, point_in, LE_in, blink, update,
      output seg_clk, seg_sout, seg_pen, seg_clrn, busy
   );
endinterface

// File: rtl/seg7_serial_drv.sv
// Serialises eight hex digits (active-low 7-seg + dp, blink-blanked) into a 64-bit
// MSB-first frame for an external shift-register chain, then strobes the latch.
module seg7_serial_drv #(
   parameter int CLK_DIV = 2,
   parameter int REFRESH = 50000
) (
   input  logic             clk,
   input  logic             rst,
   seg7_serial_drv_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;

   localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [19:0] REF_LAST = 20'(REFRESH - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [19:0] r_refresh;
   logic        r_pending;
   logic [7:0]  r_div;
   logic [5:0]  r_bit;
   logic        r_seg_clk;
   logic        r_sout;
   logic        r_pen;
   logic        r_clrn;
   logic [63:0] r_frame;
   logic [63:0] w_frame_new;
   logic        w_div_end;
   logic        w_bit_end;
   logic        w_more;

   function automatic logic [7:0] enc_byte(input logic [3:0] dig, input logic dp,
                                           input logic blank);
      logic [6:0] pat;
      case (dig)
         4'h0: pat = 7'h3F;  4'h1: pat = 7'h06;  4'h2: pat = 7'h5B;  4'h3: pat = 7'h4F;
         4'h4: pat = 7'h66;  4'h5: pat = 7'h6D;  4'h6: pat = 7'h7D;  4'h7: pat = 7'h07;
         4'h8: pat = 7'h7F;  4'h9: pat = 7'h6F;  4'hA: pat = 7'h77;  4'hB: pat = 7'h7C;
         4'hC: pat = 7'h39;  4'hD: pat = 7'h5E;  4'hE: pat = 7'h79;  default: pat = 7'h71;
      endcase
      return blank ? 8'hFF : ~{dp, pat};
   endfunction

   always_comb begin
      w_frame_new = '0;
      for (int k = 0; k < 8; k++) begin
         w_frame_new[8*k +: 8] = enc_byte(bus.Disp_num[4*k +: 4], bus.point_in[k],
                                          bus.LE_in[k] & bus.blink);
      end
   end

   assign w_div_end = (r_div == DIV_LAST);
   // End of a high phase in SHIFT: one full bit has been clocked out.
   assign w_bit_end = (r_state == SHIFT) && w_div_end && r_seg_clk;
   assign w_more    = r_pending | bus.update;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (bus.update || (r_refresh == 20'd0)) w_state_nxt = LOAD;
         LOAD:    w_state_nxt = SHIFT;
         SHIFT:   if (w_bit_end && (r_bit == 6'd63)) w_state_nxt = LATCH;
         LATCH:   if (w_div_end) w_state_nxt = w_more ? LOAD : IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_refresh <= REF_LAST;
         r_pending <= 1'b0;
         r_div     <= '0;
         r_bit     <= '0;
         r_seg_clk <= 1'b0;
         r_sout    <= 1'b1;
         r_pen     <= 1'b0;
         r_clrn    <= 1'b0;
      end else begin
         r_clrn <= 1'b1;
         case (r_state)
            IDLE: begin
               if (r_refresh != 20'd0) r_refresh <= r_refresh - 20'd1;
            end
            LOAD: begin
               r_pending <= w_more;
               r_div     <= '0;
               r_bit     <= '0;
               r_seg_clk <= 1'b0;
               r_sout    <= w_frame_new[63];
            end
            SHIFT: begin
               r_pending <= w_more;
               if (w_div_end) begin
                  r_div <= '0;
                  if (!r_seg_clk) begin
                     r_seg_clk <= 1'b1;
                  end else begin
                     r_seg_clk <= 1'b0;
                     if (r_bit == 6'd63) begin
                        r_pen <= 1'b1;
                     end else begin
                        r_bit  <= r_bit + 6'd1;
                        r_sout <= r_frame[62];
                     end
                  end
               end else begin
                  r_div <= r_div + 8'd1;
               end
            end
            LATCH: begin
               if (w_div_end) begin
                  r_div     <= '0;
                  r_pen     <= 1'b0;
                  r_refresh <= REF_LAST;
                  // A pending request is consumed by the back-to-back frame.
                  r_pending <= 1'b0;
               end else begin
                  r_div     <= r_div + 8'd1;
                  r_pending <= w_more;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (r_state == LOAD)                  r_frame <= w_frame_new;
      else if (w_bit_end && r_bit != 6'd63) r_frame <= {r_frame[62:0], 1'b0};
   end

   assign bus.seg_clk  = r_seg_clk;
   assign bus.seg_sout = r_sout;
   assign bus.seg_pen  = r_pen;
   assign bus.seg_clrn = r_clrn;
   assign bus.busy     = (r_state != IDLE);
endmodule

// File: tb/tb_seg7_serial_drv.sv
// Bench for seg7_serial_drv: a bit-level monitor rebuilds each latched frame, which is
// compared with literal frames and with a table-driven encoding of the digits.
module tb_seg7_serial_drv;
   localparam int CLK_DIV = 2;
   localparam int REFRESH = 100;
   localparam int FRAME_CYC = 1 + 64 * 2 * CLK_DIV + CLK_DIV;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;

   seg7_serial_drv_if bus ();

   seg7_serial_drv #(.CLK_DIV(CLK_DIV), .REFRESH(REFRESH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [6:0] PAT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   function automatic logic [63:0] model(input logic [31:0] d, input logic [7:0] p,
                                         input logic [7:0] le, input logic b);
      logic [63:0] r;
      logic [7:0]  byt;
      int          idx;
      r = '0;
      for (int k = 0; k < 8; k++) begin
         idx = int'((d >> (4 * k)) & 32'hF);
         if (le[k] && b) byt = 8'hFF;
         else            byt = 8'hFF ^ {p[k], PAT[idx]};
         r = r | (64'(byt) << (8 * k));
      end
      return r;
   endfunction

   // Monitor: captures seg_sout at every seg_clk rise and records frames at seg_pen fall.
   logic [63:0] cap = '0;
   int          nbits = 0, pw = 0, hrun = 0, viol = 0;
   logic        p_clk = 1'b0, p_pen = 1'b0, p_sout = 1'b1, p_busy = 1'b0, p_load = 1'b0;
   logic [63:0] frames [$];
   int          fbits [$];
   int          fpw [$];

   always @(negedge clk) begin
      if (rst) begin
         nbits = 0; pw = 0; hrun = 0; p_load = 1'b0;
         if (bus.seg_pen !== 1'b0) viol++;
      end else begin
         if (bus.seg_clk && !p_clk) begin
            cap = {cap[62:0], bus.seg_sout};
            nbits++;
         end
         if (bus.seg_clk) hrun++;
         else if (p_clk) begin
            if (hrun != CLK_DIV) viol++;
            hrun = 0;
         end
         if (bus.seg_pen) begin
            pw++;
            if (bus.seg_clk) viol++;
         end else if (p_pen) begin
            frames.push_back(cap); fbits.push_back(nbits); fpw.push_back(pw);
            nbits = 0; pw = 0;
         end
         if (!bus.busy && (bus.seg_clk || bus.seg_pen)) viol++;
         if (bus.seg_sout !== p_sout && !(p_clk && !bus.seg_clk) && !p_load) viol++;
         p_load = bus.busy && (!p_busy || (p_pen && !bus.seg_pen));
      end
      p_clk = bus.seg_clk; p_pen = bus.seg_pen; p_sout = bus.seg_sout; p_busy = bus.busy;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic start_frame(input logic [31:0] d, input logic [7:0] p,
                              input logic [7:0] le, input logic b);
      int i;
      for (i = 0; i < 1000; i++) begin
         if (!bus.busy) break;
         step();
      end
      if (i == 1000) chk("wait_idle_timeout", 64'(i), 64'd0);
      frames.delete(); fbits.delete(); fpw.delete();
      bus.Disp_num = d; bus.point_in = p; bus.LE_in = le; bus.blink = b;
      bus.update = 1'b1;
      step();
      bus.update = 1'b0;
   endtask

   // Counts busy cycles from the LOAD sample until busy falls, pulsing update at offsets.
   task automatic run_busy(input int ua, input int ub, input int uc, input bit scr,
                           output int n);
      n = 1;
      for (int i = 1; i < 3000; i++) begin
         step();
         if (!bus.busy) break;
         n++;
         bus.update = (i == ua) || (i == ub) || (i == uc);
         if (scr && i == 1) begin
            bus.Disp_num = $urandom; bus.point_in = 8'($urandom);
            bus.LE_in = 8'($urandom); bus.blink = ~bus.blink;
         end
      end
      bus.update = 1'b0;
   endtask

   task automatic do_frame(input string tag, input logic [31:0] d, input logic [7:0] p,
                           input logic [7:0] le, input logic b, input bit scr,
                           input logic [63:0] exp);
      int n;
      start_frame(d, p, le, b);
      run_busy(0, 0, 0, scr, n);
      chk({tag, "_busy_len"}, 64'(n), 64'(FRAME_CYC));
      chk({tag, "_nframes"}, 64'(frames.size()), 64'd1);
      if (frames.size() > 0) begin
         chk({tag, "_data"}, frames[0], exp);
         chk({tag, "_bits"}, 64'(fbits[0]), 64'd64);
         chk({tag, "_pen_w"}, 64'(fpw[0]), 64'(CLK_DIV));
      end
   endtask

   initial begin
      logic [31:0] d;
      logic [7:0]  p, le;
      logic        b;
      int          n, i, k;

      bus.Disp_num = '0; bus.point_in = '0; bus.LE_in = '0; bus.blink = 1'b0;
      bus.update = 1'b0;
      repeat (3) step();
      chk("rst_seg_clk", 64'(bus.seg_clk), 64'd0);
      chk("rst_sout", 64'(bus.seg_sout), 64'd1);
      chk("rst_pen", 64'(bus.seg_pen), 64'd0);
      chk("rst_clrn", 64'(bus.seg_clrn), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("clrn_before_edge", 64'(bus.seg_clrn), 64'd0);
      step();
      chk("clrn_after_edge", 64'(bus.seg_clrn), 64'd1);

      do_frame("zeros", 32'h0, 8'h00, 8'h00, 1'b0, 1'b0, 64'hC0C0C0C0C0C0C0C0);
      do_frame("hex_dp", 32'h89ABCDEF, 8'h01, 8'h00, 1'b0, 1'b0, 64'h80908883C6A1860E);
      do_frame("blank", 32'h01234567, 8'h00, 8'hFF, 1'b1, 1'b0, 64'hFFFFFFFFFFFFFFFF);
      do_frame("noblank", 32'h01234567, 8'h00, 8'hFF, 1'b0, 1'b0, 64'hC0F9A4B0999282F8);
      do_frame("late_chg", 32'h89ABCDEF, 8'h01, 8'h00, 1'b0, 1'b1, 64'h80908883C6A1860E);
      for (int r = 0; r < 6; r++) begin
         d = $urandom; p = 8'($urandom); le = 8'($urandom); b = 1'($urandom);
         do_frame("rand", d, p, le, b, 1'b1, model(d, p, le, b));
      end

      // Update in the cycle the refresh counter expires: one frame only.
      frames.delete(); fbits.delete(); fpw.delete();
      for (int j = 1; j < REFRESH; j++) step();
      chk("coinc_idle", 64'(bus.busy), 64'd0);
      bus.update = 1'b1;
      step();
      bus.update = 1'b0;
      chk("coinc_load", 64'(bus.busy), 64'd1);
      run_busy(0, 0, 0, 1'b0, n);
      chk("coinc_len", 64'(n), 64'(FRAME_CYC));
      chk("coinc_nframes", 64'(frames.size()), 64'd1);

      // Several updates during one frame: exactly one extra back-to-back frame.
      d = $urandom; p = 8'($urandom);
      start_frame(d, p, 8'h00, 1'b0);
      run_busy(10, 100, 200, 1'b0, n);
      chk("multi_len", 64'(n), 64'(2 * FRAME_CYC));
      chk("multi_nframes", 64'(frames.size()), 64'd2);
      if (frames.size() == 2) begin
         chk("multi_data0", frames[0], model(d, p, 8'h00, 1'b0));
         chk("multi_data1", frames[1], model(d, p, 8'h00, 1'b0));
      end

      // Reset at the 30th seg_clk rise aborts the frame without a latch strobe.
      start_frame(32'h13579BDF, 8'h00, 8'h00, 1'b0);
      for (i = 0; i < 2000; i++) begin
         if (nbits >= 30) break;
         step();
      end
      chk("abort_reach30", 64'(nbits), 64'd30);
      rst = 1'b1;
      #1;
      chk("abort_seg_clk", 64'(bus.seg_clk), 64'd0);
      chk("abort_sout", 64'(bus.seg_sout), 64'd1);
      chk("abort_pen", 64'(bus.seg_pen), 64'd0);
      chk("abort_clrn", 64'(bus.seg_clrn), 64'd0);
      chk("abort_busy", 64'(bus.busy), 64'd0);
      repeat (3) step();
      @(negedge clk);
      rst = 1'b0;
      for (k = 1; k < 300; k++) begin
         step();
         if (bus.busy) break;
      end
      chk("refresh_first_load", 64'(k), 64'(REFRESH));
      chk("abort_no_frame", 64'(frames.size()), 64'd0);

      chk("monitor_violations", 64'(viol), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/seg7_serial_drv.md
SEG7_SERIAL_DRV -- requirements
Module: seg7_serial_drv

Interface
REQ-001 Parameter CLK_DIV, default 2: number of clk cycles in each seg_clk phase (low or high); legal range 1..255.
REQ-002 Parameter REFRESH, default 50000: number of clk cycles spent in IDLE between self-started frames; legal range 1..2^20.
REQ-003 Port clk  in  1  the single clock; every register samples on its rising edge.
REQ-004 Port rst  in  1  asynchronous, active-high reset.
REQ-005 Port Disp_num  in  32  eight hex digits; digit k is Disp_num[4k+3:4k].
REQ-006 Port point_in  in  8  decimal-point request; bit k = 1 lights the dp of digit k.
REQ-007 Port LE_in  in  8  blink enable; bit k = 1 makes digit k blink.
REQ-008 Port blink  in  1  blink phase; 1 = blanking phase.
REQ-009 Port update  in  1  single-cycle request to start a frame now.
REQ-010 Port seg_clk  out  1  serial shift clock to the external shift-register chain.
REQ-011 Port seg_sout  out  1  serial data to the chain.
REQ-012 Port seg_pen  out  1  latch (parallel-enable) strobe to the chain.
REQ-013 Port seg_clrn  out  1  active-low clear to the chain.
REQ-014 Port busy  out  1  high whenever state is not IDLE.

Function
REQ-015 Each digit SHALL be encoded as an active-low byte {dp,g,f,e,d,c,b,a}; a 0 bit turns that segment on.
REQ-016 The gfedcba patterns in active-high form SHALL be: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71; the module inverts them for output.
REQ-017 When LE_in[k] & blink = 1, byte k SHALL be 8'hFF (blanked, dp included); otherwise byte k = ~{point_in[k], pattern}.
REQ-018 The frame SHALL be 64 bits {byte7,...,byte0}, shifted MSB first, so bit 63 is first and bit 0 is last.
REQ-019 The FSM SHALL have four states: IDLE, LOAD, SHIFT and LATCH.
REQ-020 In IDLE, a 20-bit refresh counter counts down from REFRESH-1; at 0, or when update = 1, the next state SHALL be LOAD.
REQ-021 LOAD SHALL last exactly 1 cycle; it snapshots Disp_num, point_in, LE_in and blink into the 64-bit frame, then goes to SHIFT.
REQ-022 Inputs SHALL have no effect on a frame after its LOAD cycle.
REQ-023 Each bit in SHIFT SHALL take 2*CLK_DIV cycles: seg_clk low for CLK_DIV cycles with seg_sout already valid, then high for CLK_DIV cycles.
REQ-024 seg_sout SHALL change only on the cycle seg_clk falls, or on the first SHIFT cycle.
REQ-025 Each frame SHALL produce exactly 64 seg_clk rising edges, counted by a 6-bit counter; after the 64th high phase, go to LATCH.
REQ-026 In LATCH, seg_pen SHALL be 1 for CLK_DIV cycles with seg_clk = 0; then go to IDLE and reload the refresh counter.
REQ-027 seg_pen SHALL be 0 in every other state.
REQ-028 An update pulse while busy = 1 SHALL set a pending flag; on leaving LATCH with pending = 1, the next state is LOAD (IDLE skipped) and pending clears.
REQ-029 Multiple update pulses within one frame SHALL yield exactly one extra frame.
REQ-030 An update pulse in the same cycle the refresh counter reaches 0 SHALL start one frame, not two.
REQ-031 In IDLE, seg_clk and seg_pen SHALL be 0 and seg_sout SHALL hold its last value.
REQ-032 Frame length for CLK_DIV = 2 SHALL be 1 + 256 + 2 = 259 cycles with busy = 1.

Reset
REQ-033 While rst = 1 the module SHALL be in state IDLE with seg_clk=0, seg_sout=1, seg_pen=0, seg_clrn=0 and busy=0.
REQ-034 While rst = 1, the refresh counter = REFRESH-1 and pending = 0.
REQ-035 seg_clrn SHALL go to 1 on the first clk edge after rst deasserts and stay 1.
REQ-036 rst asserted mid-SHIFT or mid-LATCH SHALL abort the frame immediately, with no seg_pen pulse issued for the partial frame.

Verification
REQ-037 Disp_num=32'h00000000, point_in=0, LE_in=0, update pulse -> 64 bits captured on seg_clk rises are eight bytes of 8'hC0, followed by one seg_pen pulse 2 cycles wide.
REQ-038 Disp_num=32'h89ABCDEF, point_in=8'h01, LE_in=0 -> bytes 7..0 = 80,90,88,83,C6,A1,86,0E.
REQ-039 Disp_num=32'h01234567, LE_in=8'hFF, blink=1 -> all bytes FF; with blink=0 -> C0,F9,A4,B0,99,92,82,F8.
REQ-040 Three update pulses during one frame -> exactly two back-to-back frames, busy never drops between them, then return to IDLE.
REQ-041 rst pulsed at the 30th seg_clk rise -> seg_pen stays 0 and outputs take reset values; with REFRESH=100 and no update, the first frame's LOAD occurs 100 cycles after reset release.
REQ-042 Disp_num changed 1 cycle after LOAD -> shifted data matches the pre-change value.
